// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared aluop codes, HILO FSM encoding and sizing helpers for the HI/LO execution unit.
package hilo_muldiv_unit_pkg;

  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  typedef enum logic [1:0] {
    HiloIdle = 2'd0,
    HiloMul  = 2'd1,
    HiloDiv  = 2'd2
  } hilo_state_e;

  // Divider step counter runs 0..width-1.
  function automatic int unsigned hilo_div_cnt_w(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  function automatic logic is_hilo_op(input logic [7:0] op);
    return op inside {EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP,
                      EXE_DIV_OP, EXE_DIVU_OP};
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per clock.
module hilo_muldiv_unit_div_radix2
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CntW = hilo_div_cnt_w(WIDTH);

  logic             running_q, running_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs_q};

  // Borrow out of the trial subtract means restore (keep the shifted remainder).
  always_comb begin
    step_rem = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  assign valid_o = running_q & (cnt_q == CntW'(WIDTH - 1));
  assign quo_o   = step_quo;
  assign rem_o   = step_rem;

  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    if (abort_i) begin
      running_d = 1'b0;
    end else if (start_i) begin
      running_d = 1'b1;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = dividend_i;
      dvs_d     = divisor_i;
    end else if (running_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CntW'(1);
      if (valid_o) running_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns HI/LO and stalls while busy.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned MulCntW = $clog2(MUL_LAT) + 1;

  hilo_state_e          state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   mul_prod_q, mul_prod_d;
  logic [MulCntW-1:0]   mul_cnt_q, mul_cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic                 is_mul, is_div, is_mov, op_signed, b_zero, issue;
  logic                 ext_a, ext_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 div_start, div_abort, div_valid;
  logic [WIDTH-1:0]     div_quo, div_rem, quo_fix, rem_fix;

  assign is_mul    = (aluop == EXE_MULT_OP) || (aluop == EXE_MULTU_OP);
  assign is_div    = (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  assign is_mov    = (aluop == EXE_MTHI_OP) || (aluop == EXE_MTLO_OP);
  assign op_signed = (aluop == EXE_MULT_OP) || (aluop == EXE_DIV_OP);
  assign b_zero    = (b == '0);
  assign issue     = start & ~flush & (state_q == HiloIdle) & is_hilo_op(aluop);

  assign ext_a = op_signed & a[WIDTH-1];
  assign ext_b = op_signed & b[WIDTH-1];

  // Low 2*WIDTH bits of the extended product are correct for both signed and unsigned forms.
  assign prod  = {{WIDTH{ext_a}}, a} * {{WIDTH{ext_b}}, b};

  assign a_mag = ext_a ? -a : a;
  assign b_mag = ext_b ? -b : b;

  assign div_start = issue & is_div & ~b_zero;
  assign div_abort = flush & (state_q == HiloDiv);

  assign quo_fix = neg_quo_q ? -div_quo : div_quo;
  assign rem_fix = neg_rem_q ? -div_rem : div_rem;

  assign busy = div_start | (issue & is_mul & (MUL_LAT > 1)) | (state_q != HiloIdle);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  hilo_muldiv_unit_div_radix2 #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .valid_o    (div_valid),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    mul_prod_d = mul_prod_q;
    mul_cnt_d  = mul_cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    unique case (state_q)
      HiloIdle: begin
        if (issue) begin
          if (is_mov) begin
            if (aluop == EXE_MTHI_OP) hi_d = a;
            else                      lo_d = a;
            done_d = 1'b1;
          end else if (is_mul) begin
            if (MUL_LAT == 1) begin
              {hi_d, lo_d} = prod;
              done_d       = 1'b1;
            end else begin
              mul_prod_d = prod;
              mul_cnt_d  = MulCntW'(1);
              state_d    = HiloMul;
            end
          end else if (b_zero) begin
            hi_d   = a;
            lo_d   = '1;
            done_d = 1'b1;
          end else begin
            neg_quo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = ext_a;
            state_d   = HiloDiv;
          end
        end
      end
      HiloMul: begin
        if (flush) begin
          state_d = HiloIdle;
        end else if (mul_cnt_q == MulCntW'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = mul_prod_q;
          done_d       = 1'b1;
          state_d      = HiloIdle;
        end else begin
          mul_cnt_d = mul_cnt_q + MulCntW'(1);
        end
      end
      HiloDiv: begin
        // Flush beats a same-cycle final divide step.
        if (flush) begin
          state_d = HiloIdle;
        end else if (div_valid) begin
          lo_d    = quo_fix;
          hi_d    = rem_fix;
          done_d  = 1'b1;
          state_d = HiloIdle;
        end
      end
      default: state_d = HiloIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= HiloIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      mul_prod_q <= '0;
      mul_cnt_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      mul_prod_q <= mul_prod_d;
      mul_cnt_q  <= mul_cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: default build plus a MUL_LAT=3 build sharing inputs.
module tb_hilo_muldiv_unit;

  localparam logic [7:0] OpMthi  = 8'b00010001;
  localparam logic [7:0] OpMtlo  = 8'b00010011;
  localparam logic [7:0] OpMult  = 8'b00011000;
  localparam logic [7:0] OpMultu = 8'b00011001;
  localparam logic [7:0] OpDiv   = 8'b00011010;
  localparam logic [7:0] OpDivu  = 8'b00011011;
  localparam logic [7:0] OpAdd   = 8'b00100000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, start3;
  logic [7:0]  aluop;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done, busy3, done3;
  logic [31:0] hi, lo, hi3, lo3;

  int checks   = 0;
  int failures = 0;
  int nbusy, ndone, done_at;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(
    .WIDTH   (32),
    .MUL_LAT (1)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .aluop  (aluop),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  hilo_muldiv_unit #(
    .WIDTH   (32),
    .MUL_LAT (3)
  ) u_dut3 (
    .clk    (clk),
    .resetn (resetn),
    .start  (start3),
    .aluop  (aluop),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy3),
    .done   (done3),
    .hi_o   (hi3),
    .lo_o   (lo3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observe from the issue cycle onward for a fixed window; cyc 0 is the issue cycle.
  task automatic track(input bit use3, output int nb, output int nd, output int dat);
    nb  = 0;
    nd  = 0;
    dat = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (use3 ? busy3 : busy) nb++;
      if (use3 ? done3 : done) begin
        nd++;
        if (dat < 0) dat = cyc;
      end
      @(negedge clk);
      start  = 1'b0;
      start3 = 1'b0;
    end
  endtask

  task automatic run_op(input bit use3, input logic [7:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output int nb, output int nd, output int dat);
    @(negedge clk);
    aluop = op;
    a     = av;
    b     = bv;
    if (use3) start3 = 1'b1;
    else      start  = 1'b1;
    track(use3, nb, nd, dat);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    aluop  = '0;
    a      = '0;
    b      = '0;
    flush  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'h0);
    check_eq("rst_hi3", hi3, 32'h0);
    resetn = 1'b1;

    run_op(1'b0, OpMult, 32'hFFFF_FFFE, 32'd3, nbusy, ndone, done_at);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFFA);
    check_eq("mult_busy", nbusy, 32'd0);
    check_eq("mult_done_at", done_at, 32'd1);

    run_op(1'b0, OpMultu, 32'hFFFF_FFFE, 32'd3, nbusy, ndone, done_at);
    check_eq("multu_hi", hi, 32'h0000_0002);
    check_eq("multu_lo", lo, 32'hFFFF_FFFA);
    check_eq("multu_busy", nbusy, 32'd0);

    run_op(1'b0, OpDiv, 32'hFFFF_FFF9, 32'd2, nbusy, ndone, done_at);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    check_eq("div_busy", nbusy, 32'd33);
    check_eq("div_ndone", ndone, 32'd1);
    check_eq("div_done_at", done_at, 32'd33);

    run_op(1'b0, OpDivu, 32'd100, 32'd7, nbusy, ndone, done_at);
    check_eq("divu_lo", lo, 32'd14);
    check_eq("divu_hi", hi, 32'd2);

    run_op(1'b0, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, nbusy, ndone, done_at);
    check_eq("divmin_lo", lo, 32'h8000_0000);
    check_eq("divmin_hi", hi, 32'h0);

    run_op(1'b0, OpDivu, 32'h0000_1234, 32'd0, nbusy, ndone, done_at);
    check_eq("dz_hi", hi, 32'h0000_1234);
    check_eq("dz_lo", lo, 32'hFFFF_FFFF);
    check_eq("dz_busy", nbusy, 32'd0);
    check_eq("dz_done_at", done_at, 32'd1);

    run_op(1'b0, OpMthi, 32'hAA, 32'd0, nbusy, ndone, done_at);
    check_eq("mthi_done_at", done_at, 32'd1);
    check_eq("mthi_busy", nbusy, 32'd0);
    run_op(1'b0, OpMtlo, 32'h55, 32'd0, nbusy, ndone, done_at);
    check_eq("mthi_hi", hi, 32'hAA);
    check_eq("mtlo_lo", lo, 32'h55);

    run_op(1'b0, OpAdd, 32'h1111, 32'h2222, nbusy, ndone, done_at);
    check_eq("bad_ndone", ndone, 32'd0);
    check_eq("bad_busy", nbusy, 32'd0);
    check_eq("bad_hi", hi, 32'hAA);

    // Flush on divide iteration 10, then issue DIVU immediately.
    @(negedge clk);
    aluop = OpDiv;
    a     = 32'd100;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("flush_busy_pre", {31'b0, busy}, 32'h1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_busy_post", {31'b0, busy}, 32'h0);
    check_eq("flush_done", {31'b0, done}, 32'h0);
    check_eq("flush_hi", hi, 32'hAA);
    check_eq("flush_lo", lo, 32'h55);
    aluop = OpDivu;
    a     = 32'd9;
    b     = 32'd4;
    start = 1'b1;
    track(1'b0, nbusy, ndone, done_at);
    check_eq("reissue_done_at", done_at, 32'd33);
    check_eq("reissue_busy", nbusy, 32'd33);
    check_eq("reissue_lo", lo, 32'd2);
    check_eq("reissue_hi", hi, 32'd1);

    // Async reset during divide iteration 5.
    @(negedge clk);
    aluop = OpDiv;
    a     = 32'd50;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_hi", hi, 32'h0);
    check_eq("arst_lo", lo, 32'h0);
    check_eq("arst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(1'b1, OpMult, 32'hFFFF_FFFE, 32'd3, nbusy, ndone, done_at);
    check_eq("mul3_busy", nbusy, 32'd3);
    check_eq("mul3_done_at", done_at, 32'd3);
    check_eq("mul3_ndone", ndone, 32'd1);
    check_eq("mul3_hi", hi3, 32'hFFFF_FFFF);
    check_eq("mul3_lo", lo3, 32'hFFFF_FFFA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
